// File: rtl/inst_axi_rom_slave.sv
// ---------------------------------------------------------------------------
// inst_axi_rom_slave
// Read-only AXI3-style responder for the instruction-fetch path. Serves one
// read request at a time from a word-addressed on-chip array after a fixed
// initial latency, with full rready backpressure. The array is filled through
// a backdoor port that is honoured only while the responder is idle.
//
// Ports
//   clk, resetn                 clock, synchronous active-low reset
//   arid/araddr/arlen/arsize/   read address channel (arsize must be 3'b010,
//   arburst/arvalid/arready     arburst FIXED/INCR/WRAP)
//   rid/rdata/rresp/rlast/      read data channel, all outputs registered and
//   rvalid/rready               zero while rvalid is low
//   load_en/load_addr/load_data backdoor word write (word index, not bytes)
// ---------------------------------------------------------------------------
module inst_axi_rom_slave #(
   parameter int MEM_WORDS  = 4096,
   parameter int ID_WIDTH   = 4,
   parameter int RD_LATENCY = 2
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic [ID_WIDTH-1:0] arid,
   input  logic [31:0]         araddr,
   input  logic [3:0]          arlen,
   input  logic [2:0]          arsize,
   input  logic [1:0]          arburst,
   input  logic                arvalid,
   output logic                arready,
   output logic [ID_WIDTH-1:0] rid,
   output logic [31:0]         rdata,
   output logic [1:0]          rresp,
   output logic                rlast,
   output logic                rvalid,
   input  logic                rready,
   input  logic                load_en,
   input  logic [31:0]         load_addr,
   input  logic [31:0]         load_data
);

   localparam int IDX_W = $clog2(MEM_WORDS);
   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_BURST = 2'd2
   } state_t;

   logic [31:0] mem_q [MEM_WORDS];

   state_t              state_q,   state_d;
   logic                arready_q, arready_d;
   logic                rvalid_q,  rvalid_d;
   logic                rlast_q,   rlast_d;
   logic [1:0]          rresp_q,   rresp_d;
   logic [ID_WIDTH-1:0] rid_q,     rid_d;
   logic [31:0]         rdata_q,   rdata_d;
   logic [ID_WIDTH-1:0] id_q,      id_d;
   logic [IDX_W-1:0]    idx_q,     idx_d;
   logic [3:0]          len_q,     len_d;
   logic [1:0]          burst_q,   burst_d;
   logic                err_q,     err_d;
   logic [3:0]          beat_q,    beat_d;
   logic [3:0]          cnt_q,     cnt_d;

   logic [IDX_W-1:0]    ar_idx_s;
   logic [IDX_W-1:0]    load_idx_s;
   logic [IDX_W-1:0]    nxt_idx_s;
   logic                wrap_len_ok_s;
   logic                as_incr_s;
   logic                ar_err_s;
   logic [1:0]          ar_burst_eff_s;
   logic                load_ok_s;
   logic                ar_hs_s;
   logic                rd_hs_s;
   logic [31:0]         first_data_s;
   logic                unused_addr_s;

   // Next array index after a beat; WRAP keeps the bits above the wrap
   // boundary and lets only the low bits (mask = len) roll over.
   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                 input logic [1:0]       burst,
                                                 input logic [3:0]       len);
      logic [IDX_W-1:0] mask;
      mask = IDX_W'(len);
      case (burst)
         BURST_FIXED: next_idx = idx;
         BURST_WRAP:  next_idx = (idx & ~mask) | ((idx + IDX_ONE) & mask);
         default:     next_idx = idx + IDX_ONE;
      endcase
   endfunction

   assign ar_idx_s      = araddr[IDX_W+1:2];
   assign load_idx_s    = load_addr[IDX_W-1:0];
   assign wrap_len_ok_s = (arlen == 4'd1) || (arlen == 4'd3) || (arlen == 4'd7) || (arlen == 4'd15);
   // Reserved bursts and WRAP with an unsupported length fall back to INCR.
   assign as_incr_s      = (arburst == BURST_RSVD) || ((arburst == BURST_WRAP) && !wrap_len_ok_s);
   assign ar_err_s       = (arsize != 3'b010) || as_incr_s;
   assign ar_burst_eff_s = as_incr_s ? BURST_INCR : arburst;
   // Loads are frozen outside IDLE so an in-flight burst sees stable data.
   assign load_ok_s     = load_en && (state_q == ST_IDLE);
   assign ar_hs_s       = (state_q == ST_IDLE) && arvalid && arready_q;
   assign rd_hs_s       = rvalid_q && rready;
   assign nxt_idx_s     = next_idx(idx_q, burst_q, len_q);
   // A load landing on the requested word in the handshake cycle must be
   // visible when the first beat is captured on that same edge.
   assign first_data_s  = (load_ok_s && (load_idx_s == ar_idx_s)) ? load_data : mem_q[ar_idx_s];
   assign unused_addr_s = ^{araddr[31:IDX_W+2], araddr[1:0], load_addr[31:IDX_W]};

   // Next-state and next-output computation for the request FSM.
   always_comb begin
      state_d   = state_q;
      rvalid_d  = rvalid_q;
      rlast_d   = rlast_q;
      rresp_d   = rresp_q;
      rid_d     = rid_q;
      rdata_d   = rdata_q;
      id_d      = id_q;
      idx_d     = idx_q;
      len_d     = len_q;
      burst_d   = burst_q;
      err_d     = err_q;
      beat_d    = beat_q;
      cnt_d     = cnt_q;
      // arready lags IDLE by one cycle, giving the bubble after each burst.
      arready_d = (state_q == ST_IDLE) && !ar_hs_s;

      case (state_q)
         ST_IDLE: begin
            if (ar_hs_s) begin
               id_d    = arid;
               idx_d   = ar_idx_s;
               len_d   = arlen;
               burst_d = ar_burst_eff_s;
               err_d   = ar_err_s;
               beat_d  = 4'd0;
               if (RD_LATENCY == 1) begin
                  state_d  = ST_BURST;
                  rvalid_d = 1'b1;
                  rdata_d  = first_data_s;
                  rid_d    = arid;
                  rresp_d  = ar_err_s ? RESP_SLVERR : RESP_OKAY;
                  rlast_d  = (arlen == 4'd0);
               end else begin
                  state_d  = ST_WAIT;
                  cnt_d    = 4'(RD_LATENCY - 1);
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d  = ST_BURST;
               rvalid_d = 1'b1;
               rdata_d  = mem_q[idx_q];
               rid_d    = id_q;
               rresp_d  = err_q ? RESP_SLVERR : RESP_OKAY;
               rlast_d  = (len_q == 4'd0);
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_BURST: begin
            if (rd_hs_s) begin
               if (rlast_q) begin
                  state_d  = ST_IDLE;
                  rvalid_d = 1'b0;
                  rlast_d  = 1'b0;
                  rresp_d  = RESP_OKAY;
                  rid_d    = '0;
                  rdata_d  = 32'h0000_0000;
               end else begin
                  beat_d  = beat_q + 4'd1;
                  idx_d   = nxt_idx_s;
                  rdata_d = mem_q[nxt_idx_s];
                  rlast_d = ((beat_q + 4'd1) == len_q);
               end
            end else begin
               state_d = ST_BURST;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            rvalid_d = 1'b0;
         end
      endcase
   end

   // FSM and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= ST_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rresp_q   <= RESP_OKAY;
         rid_q     <= '0;
         rdata_q   <= 32'h0000_0000;
         id_q      <= '0;
         idx_q     <= '0;
         len_q     <= 4'd0;
         burst_q   <= BURST_FIXED;
         err_q     <= 1'b0;
         beat_q    <= 4'd0;
         cnt_q     <= 4'd0;
      end else begin
         state_q   <= state_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rlast_q   <= rlast_d;
         rresp_q   <= rresp_d;
         rid_q     <= rid_d;
         rdata_q   <= rdata_d;
         id_q      <= id_d;
         idx_q     <= idx_d;
         len_q     <= len_d;
         burst_q   <= burst_d;
         err_q     <= err_d;
         beat_q    <= beat_d;
         cnt_q     <= cnt_d;
      end
   end

   // Backdoor array write; the array contents survive reset.
   always_ff @(posedge clk) begin
      if (load_ok_s) begin
         mem_q[load_idx_s] <= load_data;
      end
   end

   assign arready = arready_q;
   assign rvalid  = rvalid_q;
   assign rlast   = rlast_q;
   assign rresp   = rresp_q;
   assign rid     = rid_q;
   assign rdata   = rdata_q;

endmodule

// File: tb/tb_inst_axi_rom_slave.sv
module tb_inst_axi_rom_slave;
   localparam int MEM_WORDS  = 4096;
   localparam int ID_WIDTH   = 4;
   localparam int RD_LATENCY = 2;

   logic                clk = 1'b0;
   logic                resetn;
   logic [ID_WIDTH-1:0] arid, rid;
   logic [31:0]         araddr, rdata, load_addr, load_data;
   logic [3:0]          arlen;
   logic [2:0]          arsize;
   logic [1:0]          arburst, rresp;
   logic                arvalid, arready, rlast, rvalid, rready, load_en;

   inst_axi_rom_slave #(
      .MEM_WORDS(MEM_WORDS), .ID_WIDTH(ID_WIDTH), .RD_LATENCY(RD_LATENCY)
   ) dut (
      .clk(clk), .resetn(resetn),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .rvalid(rvalid), .rready(rready),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   logic [31:0] mem_m [MEM_WORDS];

   typedef struct {
      logic [ID_WIDTH-1:0] id;
      logic [31:0]         addr;
      logic [3:0]          len;
      logic [2:0]          size;
      logic [1:0]          burst;
      logic [1:0]          resp;
      logic [15:0]         rpat;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit wrap_legal(input logic [3:0] len);
      return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
   endfunction

   function automatic logic [1:0] resp_of(input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
      bit err;
      err = (size != 3'd2) || (burst == 2'd3) || ((burst == 2'd2) && !wrap_legal(len));
      return err ? 2'b10 : 2'b00;
   endfunction

   // Word index of beat k, straight from the burst rules.
   function automatic int exp_idx(input int start, input logic [3:0] len, input logic [1:0] burst, input int k);
      int n;
      n = int'(len) + 1;
      if (burst == 2'd0) return start;
      if ((burst == 2'd2) && wrap_legal(len)) return (start / n) * n + ((start % n) + k) % n;
      return (start + k) % MEM_WORDS;
   endfunction

   // Must be entered at a negedge; returns at a negedge with arready high.
   // mode 0: rready=1, 1: rready from rpat, 2: random rready plus junk loads.
   task automatic read_txn(input logic [ID_WIDTH-1:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst,
                           input logic [1:0] exp_resp, input logic [15:0] rpat,
                           input int mode, input bit do_load);
      int start, k, beat, cyc, ri, ld_idx;
      logic [31:0] exp;
      start   = int'((addr >> 2) % MEM_WORDS);
      arid    = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
      arvalid = 1'b1;
      cyc = 0;
      while (arready !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      if (arready !== 1'b1) begin
         check("ar_timeout", {31'd0, arready}, 32'd1);
         arvalid = 1'b0;
         return;
      end
      if (do_load) begin
         ld_idx    = ($urandom_range(0, 1) == 0) ? start : int'($urandom_range(0, MEM_WORDS - 1));
         load_en   = 1'b1;
         load_addr = 32'(ld_idx);
         load_data = $urandom;
         mem_m[ld_idx] = load_data;
      end
      @(negedge clk);
      arvalid = 1'b0;
      load_en = 1'b0;
      k = 1;
      while (rvalid !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("latency", k, RD_LATENCY);
      if (rvalid !== 1'b1) return;
      beat = 0; cyc = 0; ri = 0;
      while (beat <= int'(len) && cyc < 200) begin
         if (rvalid !== 1'b1) begin
            check("rvalid_drop", {31'd0, rvalid}, 32'd1);
            break;
         end
         exp = mem_m[exp_idx(start, len, burst, beat)];
         check("rdata", rdata, exp);
         check("rid", rid, id);
         check("rresp", rresp, exp_resp);
         check("rlast", {31'd0, rlast}, {31'd0, beat == int'(len)});
         case (mode)
            1:       rready = (ri < 16) ? rpat[ri] : 1'b1;
            2:       rready = ($urandom_range(0, 3) != 0);
            default: rready = 1'b1;
         endcase
         ri++;
         if (mode == 2 && $urandom_range(0, 2) == 0) begin
            load_en   = 1'b1;
            load_addr = 32'((start + int'($urandom_range(0, 15))) % MEM_WORDS);
            load_data = $urandom;
         end else begin
            load_en = 1'b0;
         end
         if (rready) beat++;
         @(negedge clk);
         cyc++;
      end
      load_en = 1'b0;
      rready  = 1'b1;
      check("beat_count", beat, int'(len) + 1);
      check("rvalid_after", {31'd0, rvalid}, 32'd0);
      check("bubble_arready", {31'd0, arready}, 32'd0);
      @(negedge clk);
      check("arready_back", {31'd0, arready}, 32'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      int n, beats;
      logic [3:0]  r_len;
      logic [2:0]  r_size;
      logic [1:0]  r_burst;

      vecs[0]  = '{4'd3,  32'h0000_0400, 4'd0,  3'd2, 2'b01, 2'b00, 16'h0000}; // uncached fetch
      vecs[1]  = '{4'd5,  32'h0000_0048, 4'd7,  3'd2, 2'b10, 2'b00, 16'h0000}; // WRAP refill
      vecs[2]  = '{4'd1,  32'h0000_0080, 4'd3,  3'd2, 2'b01, 2'b00, 16'h0069}; // backpressure 1,0,0,1,0,1,1
      vecs[3]  = '{4'd2,  32'h0000_0100, 4'd1,  3'd1, 2'b01, 2'b10, 16'h0000}; // bad size
      vecs[4]  = '{4'd4,  32'h0000_0200, 4'd2,  3'd2, 2'b10, 2'b10, 16'h0000}; // WRAP len=2
      vecs[5]  = '{4'd6,  32'h0000_3FFC, 4'd2,  3'd2, 2'b01, 2'b00, 16'h0000}; // INCR past top
      vecs[6]  = '{4'd7,  32'h0000_0084, 4'd3,  3'd2, 2'b00, 2'b00, 16'h0000}; // FIXED
      vecs[7]  = '{4'd8,  32'hF000_0048, 4'd15, 3'd2, 2'b10, 2'b00, 16'h0000}; // aliased WRAP16
      vecs[8]  = '{4'd9,  32'h0000_010C, 4'd3,  3'd2, 2'b11, 2'b10, 16'h0000}; // reserved burst
      vecs[9]  = '{4'd10, 32'h0000_001C, 4'd3,  3'd2, 2'b10, 2'b00, 16'h0000}; // WRAP4 from top
      vecs[10] = '{4'd15, 32'h0000_0060, 4'd1,  3'd2, 2'b10, 2'b00, 16'h0000}; // WRAP2

      resetn = 1'b0; arvalid = 1'b0; rready = 1'b1; load_en = 1'b0;
      arid = '0; araddr = 32'h0; arlen = 4'd0; arsize = 3'd2; arburst = 2'b01;
      load_addr = 32'h0; load_data = 32'h0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);

      for (int i = 0; i < MEM_WORDS; i++) begin
         load_en   = 1'b1;
         load_addr = 32'(i);
         load_data = (i == 32'h100) ? 32'h2402_0001 : 32'(i);
         mem_m[i]  = load_data;
         @(negedge clk);
      end
      load_en = 1'b0;

      // Reset with arvalid held high.
      resetn  = 1'b0;
      arid = vecs[0].id; araddr = vecs[0].addr; arlen = vecs[0].len;
      arsize = vecs[0].size; arburst = vecs[0].burst; arvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_arready", {31'd0, arready}, 32'd0);
         check("rst_rvalid", {31'd0, rvalid}, 32'd0);
      end
      check("rst_rdata", rdata, 32'h0);
      check("rst_rid", rid, 32'h0);
      check("rst_rresp", rresp, 32'h0);
      check("rst_rlast", {31'd0, rlast}, 32'd0);
      resetn = 1'b1;
      @(negedge clk);
      check("release_arready", {31'd0, arready}, 32'd1);

      for (int v = 0; v < 11; v++) begin
         read_txn(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst,
                  vecs[v].resp, vecs[v].rpat, (vecs[v].rpat != 16'h0) ? 1 : 0, 1'b0);
      end

      // Abort: reset during beat 2 of an 8-beat burst.
      arid = 4'hA; araddr = 32'h0000_0100; arlen = 4'd7; arsize = 3'd2; arburst = 2'b01;
      arvalid = 1'b1; rready = 1'b1;
      n = 0;
      while (arready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);
      arvalid = 1'b0;
      n = 0; beats = 0;
      while (beats < 2 && n < 20) begin
         if (rvalid === 1'b1) beats++;
         @(negedge clk);
         n++;
      end
      check("abort_beat2_valid", {31'd0, rvalid}, 32'd1);
      check("abort_beat2_data", rdata, mem_m[32'h42]);
      resetn = 1'b0;
      @(negedge clk);
      check("abort_rvalid", {31'd0, rvalid}, 32'd0);
      check("abort_arready", {31'd0, arready}, 32'd0);
      resetn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("abort_no_resume", {31'd0, rvalid}, 32'd0);
      end
      read_txn(4'hC, 32'h0000_0200, 4'd3, 3'd2, 2'b01, 2'b00, 16'h0, 0, 1'b0);

      // Randomised requests, loads at the handshake and ignored loads mid-burst.
      for (int t = 0; t < 40; t++) begin
         r_len   = 4'($urandom_range(0, 15));
         r_size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
         r_burst = 2'($urandom_range(0, 3));
         read_txn(ID_WIDTH'($urandom), $urandom, r_len, r_size, r_burst,
                  resp_of(r_len, r_size, r_burst), 16'h0, 2, ($urandom_range(0, 1) == 1));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
